clarke_park_transform: RTL and testbench

Converts two ADC-sampled phase currents (Ia, Ib) plus the rotor electrical angle's sine/cosine into rotating-frame currents Id/Iq. It uses a Clarke transform followed by a Park transform. The block sits between the ADC/angle front end and the current-loop PI. oId/oIq drive the PI's measured-current inputs, and oCal_done drives the PI's rising-edge-triggered calculation enable.

---
 rtl/clarke_park_transform_if.sv | 28 ++
 rtl/clarke_park_transform.sv | 111 +++++++++++
 tb/tb_clarke_park_transform.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/clarke_park_transform_if.sv
// Bundle of the sampled-current inputs, the angle inputs, the start
// strobe and the Id/Iq results exchanged with clarke_park_transform.
//   iIa, iIb    : signed 12-bit phase currents
//   iSin, iCos  : signed Q15 sin/cos of the electrical angle
//   iCal_en     : start request (rising edge starts a conversion)
//   oId, oIq    : signed 12-bit rotating-frame currents, clamped
//   oCal_done   : one-cycle pulse when oId/oIq update
// master drives the inputs (front end / bench); slave is the transform.
interface clarke_park_transform_if;
    logic signed [11:0] iIa;
    logic signed [11:0] iIb;
    logic signed [15:0] iSin;
    logic signed [15:0] iCos;
    logic               iCal_en;
    logic signed [11:0] oId;
    logic signed [11:0] oIq;
    logic               oCal_done;

    modport master (
        output iIa, iIb, iSin, iCos, iCal_en,
        input  oId, oIq, oCal_done
    );

    modport slave (
        input  iIa, iIb, iSin, iCos, iCal_en,
        output oId, oIq, oCal_done
    );
endinterface

// File: rtl/clarke_park_transform.sv
// Clarke + Park transform: phase currents (Ia, Ib) and sin/cos of the
// rotor angle in, clamped Id/Iq out. A rising edge on iCal_en in IDLE
// captures the inputs; results and a one-cycle done pulse appear four
// clocks later (IDLE -> BETA -> PROD -> SUM -> SAT -> IDLE).
// Ports:
//   iClk   : clock
//   iRst_n : synchronous active-low reset
//   bus    : clarke_park_transform_if.slave (inputs, start, results)
module clarke_park_transform #(
    parameter logic signed [15:0] K_INV_SQRT3 = 16'sd18919,
    parameter logic signed [11:0] I_LIM       = 12'sd2047
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    clarke_park_transform_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, BETA, PROD, SUM, SAT} state_t;

    localparam logic signed [16:0] LIM_P = 17'(I_LIM);
    localparam logic signed [16:0] LIM_N = -LIM_P;

    state_t             state;
    logic               en_pre;
    logic signed [11:0] ia;
    logic signed [13:0] s;       // Ia + 2*Ib
    logic signed [15:0] sn;
    logic signed [15:0] cs;
    logic signed [12:0] ialpha;
    logic signed [12:0] ibeta;
    logic signed [28:0] pa_c, pb_s, pa_s, pb_c;
    logic signed [16:0] d, q;    // post-shift sums, wide enough for the clamp compare

    logic               start;
    logic signed [29:0] prod_b;
    logic signed [31:0] d_sum, q_sum;

    assign start  = bus.iCal_en & ~en_pre;
    assign prod_b = 30'(s) * 30'(K_INV_SQRT3);
    assign d_sum  = 32'(pa_c) + 32'(pb_s);
    assign q_sum  = 32'(pb_c) - 32'(pa_s);

    // -I_LIM is the floor, so -2048 never reaches the PI.
    function automatic logic signed [11:0] sat(input logic signed [16:0] v);
        if (v > LIM_P)      return I_LIM;
        else if (v < LIM_N) return -I_LIM;
        else                return v[11:0];
    endfunction

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state         <= IDLE;
            en_pre        <= 1'b0;
            ia            <= '0;
            s             <= '0;
            sn            <= '0;
            cs            <= '0;
            ialpha        <= '0;
            ibeta         <= '0;
            pa_c          <= '0;
            pb_s          <= '0;
            pa_s          <= '0;
            pb_c          <= '0;
            d             <= '0;
            q             <= '0;
            bus.oId       <= '0;
            bus.oIq       <= '0;
            bus.oCal_done <= 1'b0;
        end else begin
            // en_pre tracks every cycle so a level held through IDLE never retriggers
            en_pre        <= bus.iCal_en;
            bus.oCal_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ia    <= bus.iIa;
                        s     <= 14'(bus.iIa) + (14'(bus.iIb) <<< 1);
                        sn    <= bus.iSin;
                        cs    <= bus.iCos;
                        state <= BETA;
                    end
                end
                BETA: begin
                    ibeta  <= 13'(prod_b >>> 15);
                    ialpha <= 13'(ia);
                    state  <= PROD;
                end
                PROD: begin
                    pa_c  <= 29'(ialpha) * 29'(cs);
                    pb_s  <= 29'(ibeta)  * 29'(sn);
                    pa_s  <= 29'(ialpha) * 29'(sn);
                    pb_c  <= 29'(ibeta)  * 29'(cs);
                    state <= SUM;
                end
                SUM: begin
                    d     <= 17'(d_sum >>> 15);
                    q     <= 17'(q_sum >>> 15);
                    state <= SAT;
                end
                SAT: begin
                    bus.oId       <= sat(d);
                    bus.oIq       <= sat(q);
                    bus.oCal_done <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clarke_park_transform.sv
module tb_clarke_park_transform;

    logic clk;
    logic rst_n;

    clarke_park_transform_if bus();

    clarke_park_transform dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ia;
        int ib;
        int sn;
        int cs;
        int d;
        int q;
    } vec_t;

    typedef struct {
        int d;
        int q;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Golden model: floor shifts on 64-bit integers, then the symmetric clamp.
    function automatic void model(input int ia, input int ib, input int sn, input int cs,
                                  output int d, output int q);
        longint s, ibeta, dd, qq;
        s     = longint'(ia) + 2 * longint'(ib);
        ibeta = (s * 18919) >>> 15;
        dd    = (longint'(ia) * cs + ibeta * sn) >>> 15;
        qq    = (ibeta * cs - longint'(ia) * sn) >>> 15;
        d = (dd > 2047) ? 2047 : (dd < -2047) ? -2047 : int'(dd);
        q = (qq > 2047) ? 2047 : (qq < -2047) ? -2047 : int'(qq);
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (bus.oCal_done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty queue, expected none");
            end else begin
                e = exp_q.pop_front();
                chk("id", int'(bus.oId), e.d);
                chk("iq", int'(bus.oIq), e.q);
            end
        end
    end

    // Drives inputs and a rising iCal_en seen at the next posedge (E0);
    // returns at the negedge after E0 with iCal_en low again.
    task automatic start_vec(input int ia, input int ib, input int sn, input int cs,
                             input bit push);
        exp_t e;
        @(negedge clk);
        bus.iIa     = 12'(ia);
        bus.iIb     = 12'(ib);
        bus.iSin    = 16'(sn);
        bus.iCos    = 16'(cs);
        bus.iCal_en = 1'b1;
        if (push) begin
            model(ia, ib, sn, cs, e.d, e.q);
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus.iCal_en = 1'b0;
    endtask

    vec_t tbl[4];

    initial begin
        int d0, ia_r, ib_r, sn_r, cs_r;
        exp_t e;

        tbl[0] = '{ia: 1000,  ib: 0,     sn: 0,     cs: 32767, d: 999,   q: 576};
        tbl[1] = '{ia: 1000,  ib: -500,  sn: 32767, cs: 0,     d: 0,     q: -1000};
        tbl[2] = '{ia: 2047,  ib: 2047,  sn: 23170, cs: 23170, d: 2047,  q: 1059};
        tbl[3] = '{ia: -2048, ib: -2048, sn: 0,     cs: 32767, d: -2047, q: -2047};

        rst_n       = 1'b0;
        bus.iIa     = '0;
        bus.iIb     = '0;
        bus.iSin    = '0;
        bus.iCos    = '0;
        bus.iCal_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_id",   int'(bus.oId), 0);
        chk("rst_iq",   int'(bus.oIq), 0);
        chk("rst_done", int'(bus.oCal_done), 0);
        rst_n = 1'b1;

        // Table vectors: hand-derived expectations, with exact 4-clock latency.
        for (int i = 0; i < 4; i++) begin
            e.d = tbl[i].d;
            e.q = tbl[i].q;
            start_vec(tbl[i].ia, tbl[i].ib, tbl[i].sn, tbl[i].cs, 1'b0);
            exp_q.push_back(e);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (k == 3) chk("done_early", int'(bus.oCal_done), 0);
                if (k == 4) chk("done_latency", int'(bus.oCal_done), 1);
            end
            repeat (2) @(negedge clk);
        end

        // Level held high for 20 cycles: one conversion only, outputs then hold.
        d0 = done_cnt;
        @(negedge clk);
        bus.iIa = 12'sd300; bus.iIb = 12'sd200; bus.iSin = 16'sd10000; bus.iCos = 16'sd30000;
        bus.iCal_en = 1'b1;
        model(300, 200, 10000, 30000, e.d, e.q);
        exp_q.push_back(e);
        repeat (20) @(negedge clk);
        bus.iCal_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_single_done", done_cnt - d0, 1);
        chk("hold_id", int'(bus.oId), e.d);
        chk("hold_iq", int'(bus.oIq), e.q);

        // Second rising edge at E2 is dropped.
        d0 = done_cnt;
        start_vec(-700, 450, -20000, 15000, 1'b1);
        @(negedge clk);
        bus.iCal_en = 1'b1;
        @(negedge clk);
        bus.iCal_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("e2_edge_single_done", done_cnt - d0, 1);

        // Input change at E1 must not leak into the conversion.
        d0 = done_cnt;
        start_vec(1500, -300, 12000, -25000, 1'b1);
        bus.iIa = -12'sd1900;
        bus.iIb = 12'sd1000;
        repeat (6) @(negedge clk);
        chk("e1_change_done", done_cnt - d0, 1);

        // Reset at E2 aborts: no done, outputs cleared.
        d0 = done_cnt;
        start_vec(800, 800, 5000, 5000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_id", int'(bus.oId), 0);
        chk("abort_iq", int'(bus.oIq), 0);

        // Back-to-back starts every 5 clocks with random inputs.
        d0 = done_cnt;
        for (int n = 0; n < 10; n++) begin
            ia_r = int'($urandom_range(0, 4095)) - 2048;
            ib_r = int'($urandom_range(0, 4095)) - 2048;
            sn_r = int'($urandom_range(0, 65535)) - 32768;
            cs_r = int'($urandom_range(0, 65535)) - 32768;
            start_vec(ia_r, ib_r, sn_r, cs_r, 1'b1);
            repeat (3) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("burst_done_count", done_cnt - d0, 10);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
